fetch_instruction: RTL and testbench

- Instruction-fetch stage directly upstream of decode.
- Holds the program counter and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Presents {v_o, inst_o, pc_o} to decode and honours decode's stall_o (wired to stall_i here) and the branch redirect.
- A one-entry hold buffer keeps the in-flight word when decode stalls, so no fetch is lost or duplicated.

---
 rtl/fetch_instruction_pkg.sv | 24 ++
 rtl/fetch_instruction_if.sv | 25 ++
 rtl/fetch_hold_buffer.sv | 43 ++++
 rtl/fetch_instruction.sv | 67 ++++++
 tb/tb_fetch_instruction.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_instruction_pkg.sv
// Shared widths, types and PC helper for the instruction-fetch stage.
package fetch_instruction_pkg;

    localparam int unsigned WORD    = 32;
    localparam int unsigned ADDR    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef logic [ADDR-1:0] addr_t;
    typedef logic [WORD-1:0] word_t;

    localparam addr_t RESET_PC_DEFAULT = '0;

    // One fetched instruction together with its address
    typedef struct packed {
        addr_t pc;
        word_t inst;
    } fetch_entry_t;

    // Sequential successor; wraps modulo 2^ADDR
    function automatic addr_t next_pc(input addr_t pc);
        return pc + ADDR'(PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_instruction_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-facing stream.
interface fetch_instruction_if;
    import fetch_instruction_pkg::*;

    addr_t imem_addr_o;
    logic  imem_re_o;
    word_t imem_data_i;
    logic  v_o;
    word_t inst_o;
    addr_t pc_o;
    logic  stall_i;
    logic  branch_i;
    addr_t branch_addr_i;

    modport master (
        output imem_addr_o, imem_re_o, v_o, inst_o, pc_o,
        input  imem_data_i, stall_i, branch_i, branch_addr_i
    );

    modport slave (
        input  imem_addr_o, imem_re_o, v_o, inst_o, pc_o,
        output imem_data_i, stall_i, branch_i, branch_addr_i
    );

endinterface

// File: rtl/fetch_hold_buffer.sv
// One-entry skid register for the in-flight word plus the decode output mux.
module fetch_hold_buffer
    import fetch_instruction_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_capture,
    input  logic         i_clear,
    input  logic         i_fetch_v,
    input  fetch_entry_t i_fetch,
    output logic         o_hold_v,
    output logic         o_v,
    output fetch_entry_t o_out
);

    logic         r_hold_v;
    fetch_entry_t r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v <= 1'b0;
            r_hold   <= '0;
        end else if (i_clear) begin
            r_hold_v <= 1'b0;
        end else if (i_capture) begin
            r_hold_v <= 1'b1;
            r_hold   <= i_fetch;
        end
    end

    // Held word wins; an invalid live slot is forced to zero
    always_comb begin
        o_hold_v = r_hold_v;
        o_v      = r_hold_v | i_fetch_v;
        o_out    = '0;
        if (r_hold_v) begin
            o_out = r_hold;
        end else if (i_fetch_v) begin
            o_out = i_fetch;
        end
    end

endmodule

// File: rtl/fetch_instruction.sv
// Instruction-fetch stage: PC, imem read issue, redirect and stall handling.
module fetch_instruction
    import fetch_instruction_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_instruction_if.master  bus
);

    addr_t        r_pc;
    addr_t        r_fetch_pc;
    logic         r_fetch_v;
    logic         w_issue;
    logic         w_hold_v;
    logic         w_capture;
    logic         w_clear;
    logic         w_out_v;
    fetch_entry_t w_fetch;
    fetch_entry_t w_out;

    assign w_issue         = reset & (bus.branch_i | ~bus.stall_i);
    assign bus.imem_re_o   = w_issue;
    assign bus.imem_addr_o = (reset & bus.branch_i) ? bus.branch_addr_i : r_pc;

    // Park the live memory word only on the first stalled cycle
    assign w_clear   = bus.branch_i | ~bus.stall_i;
    assign w_capture = bus.stall_i & ~bus.branch_i & ~w_hold_v & r_fetch_v;
    assign w_fetch   = '{pc: r_fetch_pc, inst: bus.imem_data_i};

    fetch_hold_buffer u_hold (
        .clk       (clk),
        .rst_n     (reset),
        .i_capture (w_capture),
        .i_clear   (w_clear),
        .i_fetch_v (r_fetch_v),
        .i_fetch   (w_fetch),
        .o_hold_v  (w_hold_v),
        .o_v       (w_out_v),
        .o_out     (w_out)
    );

    assign bus.v_o    = w_out_v;
    assign bus.inst_o = w_out.inst;
    assign bus.pc_o   = w_out.pc;

    // Redirect beats stall; a stalled slot is emptied once its word is parked
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_fetch_v  <= 1'b0;
            r_fetch_pc <= '0;
        end else if (bus.branch_i) begin
            r_fetch_v  <= 1'b1;
            r_fetch_pc <= bus.branch_addr_i;
            r_pc       <= next_pc(bus.branch_addr_i);
        end else if (!bus.stall_i) begin
            r_fetch_v  <= 1'b1;
            r_fetch_pc <= r_pc;
            r_pc       <= next_pc(r_pc);
        end else if (!w_hold_v && r_fetch_v) begin
            r_fetch_v  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_instruction.sv
// Self-checking bench for fetch_instruction: directed vector table, wrap and reset sequences, random stream.
module tb_fetch_instruction;
    import fetch_instruction_pkg::*;

    localparam logic [31:0] XORK    = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fetch_instruction_if bus  ();
    fetch_instruction_if bus2 ();

    fetch_instruction dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    fetch_instruction #(.RESET_PC(WRAP_PC)) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memories: word = address ^ XORK
    logic [31:0] mem_q1 = '0;
    logic [31:0] mem_q2 = '0;
    always @(posedge clk) if (bus.imem_re_o)  mem_q1 <= bus.imem_addr_o ^ XORK;
    always @(posedge clk) if (bus2.imem_re_o) mem_q2 <= bus2.imem_addr_o ^ XORK;
    assign bus.imem_data_i  = mem_q1;
    assign bus2.imem_data_i = mem_q2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] baddr;
        logic        ev;
        logic [31:0] epc;
        logic        ere;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] ba,
                                input logic v, input logic [31:0] pc,
                                input logic re, input logic [31:0] ad);
        vec_t r;
        r.stall = s; r.br = b; r.baddr = ba;
        r.ev = v; r.epc = pc; r.ere = re; r.eaddr = ad;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check outputs
    task automatic drive_check(input logic s, input logic b, input logic [31:0] ba,
                               input logic ev, input logic [31:0] epc,
                               input logic ere, input logic [31:0] eaddr,
                               input string tag);
        @(negedge clk);
        bus.stall_i       = s;
        bus.branch_i      = b;
        bus.branch_addr_i = ba;
        #1;
        chk({tag, ".v_o"}, 32'(bus.v_o), 32'(ev));
        if (ev) begin
            chk({tag, ".pc_o"},   bus.pc_o,   epc);
            chk({tag, ".inst_o"}, bus.inst_o, epc ^ XORK);
        end
        chk({tag, ".imem_re_o"},   32'(bus.imem_re_o), 32'(ere));
        chk({tag, ".imem_addr_o"}, bus.imem_addr_o,    eaddr);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".v_o"},         32'(bus.v_o),       32'd0);
        chk({tag, ".inst_o"},      bus.inst_o,         32'd0);
        chk({tag, ".pc_o"},        bus.pc_o,           32'd0);
        chk({tag, ".imem_re_o"},   32'(bus.imem_re_o), 32'd0);
        chk({tag, ".imem_addr_o"}, bus.imem_addr_o,    32'd0);
        chk({tag, ".wrap_addr"},   bus2.imem_addr_o,   WRAP_PC);
    endtask

    // Stream-level reference: what decode sees and which PC comes next
    logic        m_v;
    logic [31:0] m_pc;
    logic [31:0] m_next;

    initial begin
        bus.stall_i        = 1'b0;
        bus.branch_i       = 1'b0;
        bus.branch_addr_i  = '0;
        bus2.stall_i       = 1'b0;
        bus2.branch_i      = 1'b0;
        bus2.branch_addr_i = '0;

        tbl[0]  = mk(0, 0, 32'h0,   0, 32'h0,   1, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,   1, 32'h0,   1, 32'h4);
        tbl[2]  = mk(0, 0, 32'h0,   1, 32'h4,   1, 32'h8);
        tbl[3]  = mk(1, 0, 32'h0,   1, 32'h8,   0, 32'hC);
        tbl[4]  = mk(1, 0, 32'h0,   1, 32'h8,   0, 32'hC);
        tbl[5]  = mk(1, 0, 32'h0,   1, 32'h8,   0, 32'hC);
        tbl[6]  = mk(0, 0, 32'h0,   1, 32'h8,   1, 32'hC);
        tbl[7]  = mk(0, 0, 32'h0,   1, 32'hC,   1, 32'h10);
        tbl[8]  = mk(0, 1, 32'h100, 1, 32'h10,  1, 32'h100);
        tbl[9]  = mk(0, 0, 32'h0,   1, 32'h100, 1, 32'h104);
        tbl[10] = mk(0, 0, 32'h0,   1, 32'h104, 1, 32'h108);
        tbl[11] = mk(1, 0, 32'h0,   1, 32'h108, 0, 32'h10C);
        tbl[12] = mk(1, 1, 32'h200, 1, 32'h108, 1, 32'h200);
        tbl[13] = mk(1, 0, 32'h0,   1, 32'h200, 0, 32'h204);
        tbl[14] = mk(0, 0, 32'h0,   1, 32'h200, 1, 32'h204);
        tbl[15] = mk(0, 0, 32'h0,   1, 32'h204, 1, 32'h208);

        // Outputs held at their cleared values during reset
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("rst");

        @(posedge clk);
        #2 reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive_check(tbl[i].stall, tbl[i].br, tbl[i].baddr,
                        tbl[i].ev, tbl[i].epc, tbl[i].ere, tbl[i].eaddr,
                        $sformatf("vec%0d", i));
            if (i >= 1 && i <= 4) begin
                chk($sformatf("wrap%0d.v_o", i),  32'(bus2.v_o), 32'd1);
                chk($sformatf("wrap%0d.pc_o", i), bus2.pc_o, WRAP_PC + 32'(4 * (i - 1)));
                chk($sformatf("wrap%0d.inst_o", i), bus2.inst_o,
                    (WRAP_PC + 32'(4 * (i - 1))) ^ XORK);
            end
        end

        // Asynchronous reset in the middle of a stall
        @(negedge clk);
        bus.stall_i  = 1'b1;
        bus.branch_i = 1'b0;
        @(posedge clk);
        #1;
        chk("areset.pre_v_o", 32'(bus.v_o), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("areset");
        @(posedge clk);
        #2 reset = 1'b1;
        drive_check(0, 0, 32'h0, 0, 32'h0, 1, 32'h0, "restart0");
        drive_check(0, 0, 32'h0, 1, 32'h0, 1, 32'h4, "restart1");
        drive_check(0, 0, 32'h0, 1, 32'h4, 1, 32'h8, "restart2");

        // Randomised stream against the reference model
        #3 reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        m_v    = 1'b0;
        m_pc   = '0;
        m_next = '0;
        for (int n = 0; n < 600; n++) begin
            logic        s;
            logic        b;
            logic [31:0] ba;
            s  = ($urandom_range(0, 99) < 40);
            b  = ($urandom_range(0, 99) < 10);
            ba = $urandom;
            if ($urandom_range(0, 3) == 0) ba = 32'hFFFF_FFF0 | (ba & 32'hC);
            drive_check(s, b, ba, m_v, m_pc, b | ~s, b ? ba : m_next, "rnd");
            @(posedge clk);
            if (b) begin
                m_v    = 1'b1;
                m_pc   = ba;
                m_next = ba + 32'd4;
            end else if (!s) begin
                m_v    = 1'b1;
                m_pc   = m_next;
                m_next = m_next + 32'd4;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
